// File: rtl/seq_exec_alu.sv
// Iterative execute-stage ALU: single-cycle logic/add/sub, serial one-bit-per-cycle
// shifts, valid/ready on both the request and the result side.
module seq_exec_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b1100;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir_left;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;
  logic               w_legal;
  logic [WIDTH-1:0]   w_alu;
  logic [WIDTH-1:0]   w_shift_next;

  assign w_shamt = b[SHAMT_W-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    w_is_shift = 1'b0;
    w_legal    = 1'b1;
    w_alu      = '0;
    case (aluctl)
      OP_ADD: w_alu = a + b;
      OP_SUB: w_alu = a - b;
      OP_AND: w_alu = a & b;
      OP_OR:  w_alu = a | b;
      OP_XOR: w_alu = a ^ b;
      // Only used for shamt == 0; non-zero shifts go through the serial path.
      OP_SLL, OP_SRL: begin
        w_is_shift = 1'b1;
        w_alu      = a;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_shift_next = r_dir_left ? {r_work[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_work[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_work     <= '0;
      r_cnt      <= '0;
      r_dir_left <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_work     <= a;
              r_cnt      <= w_shamt;
              r_dir_left <= (aluctl == OP_SLL);
              r_state    <= S_SHIFT;
            end else begin
              r_result  <= w_alu;
              r_zero    <= (w_alu == '0);
              r_illegal <= ~w_legal;
              r_state   <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_work <= w_shift_next;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_result  <= w_shift_next;
            r_zero    <= (w_shift_next == '0);
            r_illegal <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_exec_alu.sv
// Self-checking bench for seq_exec_alu: directed plan cases plus randomized ops
// compared against a behavioural model of the operation set and its latency.
module tb_seq_exec_alu;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       aluctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int n_checks = 0;
  int n_bad    = 0;

  logic [WIDTH-1:0] exp_res;
  logic             exp_zero;
  logic             exp_ill;
  int               exp_lat;

  seq_exec_alu #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluctl(aluctl), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: what the op means arithmetically and how many cycles it takes.
  task automatic ref_model(input logic [3:0] ctl, input logic [WIDTH-1:0] op_a,
                           input logic [WIDTH-1:0] op_b);
    int sh;
    sh       = int'(op_b % 32);
    exp_ill  = 1'b0;
    exp_lat  = 1;
    case (ctl)
      4'b0010: exp_res = WIDTH'((64'(op_a) + 64'(op_b)) % 64'h1_0000_0000);
      4'b0110: exp_res = WIDTH'((64'h1_0000_0000 + 64'(op_a) - 64'(op_b)) % 64'h1_0000_0000);
      4'b0000: exp_res = op_a & op_b;
      4'b0001: exp_res = op_a | op_b;
      4'b1100: exp_res = op_a ^ op_b;
      4'b0011: begin exp_res = op_a << sh; exp_lat = sh + 1; end
      4'b0100: begin exp_res = op_a >> sh; exp_lat = sh + 1; end
      default: begin exp_res = '0; exp_ill = 1'b1; end
    endcase
    exp_zero = (exp_res == 0);
  endtask

  // Presents a request (at #1 after an edge) and returns #1 after its accept edge.
  task automatic issue(input string tag, input logic [3:0] ctl,
                       input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
    check({tag, ".in_ready_before"}, 64'(in_ready), 64'd1);
    aluctl   = ctl;
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    ref_model(ctl, op_a, op_b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    aluctl   = $urandom();
    a        = $urandom();
    b        = $urandom();
  endtask

  // Called #1 after the accept edge; measures latency and checks the result.
  task automatic wait_done(input string tag);
    int lat;
    bit ready_seen;
    lat        = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".timeout"}, 64'(out_valid), 64'd1);
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".in_ready_busy"}, 64'(ready_seen | in_ready), 64'd0);
    check({tag, ".result"}, 64'(result), 64'(exp_res));
    check({tag, ".zero"}, 64'(zero), 64'(exp_zero));
    check({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
    check({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctl,
                        input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
    issue(tag, ctl, op_a, op_b);
    wait_done(tag);
    handoff(tag);
  endtask

  logic [3:0] legal_codes [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0011, 4'b0100};

  initial begin
    bit stale;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    aluctl    = '0;
    a         = '0;
    b         = '0;
    #12;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0002);
    run_op("sub_zero", 4'b0110, 32'h1234, 32'h1234);
    run_op("sub_neg", 4'b0110, 32'h0, 32'h1);
    run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("xor", 4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    run_op("sll31", 4'b0011, 32'h1, 32'd31);
    run_op("srl4", 4'b0100, 32'h8000_0000, 32'h24);
    run_op("sll0", 4'b0011, 32'hDEAD_BEEF, 32'h20);
    run_op("srl0", 4'b0100, 32'h1234_5678, 32'h0);
    run_op("illegal", 4'b0111, 32'h55, 32'h66);
    run_op("after_ill", 4'b0001, 32'h0, 32'h1);

    // Backpressure with a second request waiting.
    issue("bp", 4'b0010, 32'd100, 32'd23);
    wait_done("bp");
    aluctl   = 4'b1100;
    a        = 32'hAAAA_0000;
    b        = 32'h0000_5555;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_ready", 64'(in_ready), 64'd0);
      check("bp.hold_result", 64'(result), 64'd123);
      check("bp.hold_zero", 64'(zero), 64'd0);
      check("bp.hold_ill", 64'(illegal), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.release_ready", 64'(in_ready), 64'd1);
    check("bp.release_valid", 64'(out_valid), 64'd0);
    ref_model(4'b1100, 32'hAAAA_0000, 32'h0000_5555);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done("bp_pending");
    handoff("bp_pending");

    // Asynchronous reset in the middle of a long shift.
    issue("mid", 4'b0011, 32'h1, 32'd31);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid.out_valid", 64'(out_valid), 64'd0);
    check("mid.in_ready", 64'(in_ready), 64'd1);
    check("mid.result", 64'(result), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_op("post_rst_add", 4'b0010, 32'd5, 32'd7);
    stale = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("mid.no_stale", 64'(stale), 64'd0);

    // Randomized ops with random result-side backpressure.
    for (int n = 0; n < 40; n++) begin
      logic [3:0]       c;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      int               hold;
      c    = ($urandom_range(0, 9) < 7) ? legal_codes[$urandom_range(0, 6)] : 4'($urandom_range(0, 15));
      ra   = $urandom();
      rb   = $urandom();
      if ($urandom_range(0, 3) == 0) ra = '0;
      issue("rnd", c, ra, rb);
      wait_done("rnd");
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("rnd.hold_result", 64'(result), 64'(exp_res));
        check("rnd.hold_valid", 64'(out_valid), 64'd1);
      end
      handoff("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_exec_alu.md
Name: seq_exec_alu

Overview:
Iterative execute-stage ALU. It consumes the 4-bit ALU control code produced by the pipeline's ALU-control decoder, together with two operands, over a valid/ready handshake. Logic ops and add/sub complete in one cycle. Shifts run serially, one bit per cycle. The result is held on a valid/ready output channel toward the EX/MEM register until it is accepted.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; shamt = b[SHAMT_W-1:0]

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request
aluctl  input  4  ALU control code
a  input  WIDTH  operand A
b  input  WIDTH  operand B; low SHAMT_W bits are shamt for shifts
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  WIDTH  operation result
zero  output  1  result == 0
illegal  output  1  aluctl was not a supported code

Behaviour:
- Supported codes:
  - 0010 add: a+b, modulo 2^WIDTH, carry discarded.
  - 0110 sub: a-b, two's complement, modulo 2^WIDTH.
  - 0000 and.
  - 0001 or.
  - 1100 xor.
  - 0011 sll: logical left shift by shamt.
  - 0100 srl: logical right shift by shamt, zero fill.
- Any other code: result=0, zero=1, illegal=1; completes like a 1-cycle op.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Acceptance: a request is accepted on a rising edge where in_valid && in_ready. aluctl, a and b are captured at that edge. Inputs are ignored at all other times.
- Transitions from IDLE on accept:
  - Non-shift or illegal code: result computed and registered, go to DONE. out_valid is asserted the cycle after acceptance (latency 1).
  - Shift with shamt=0: result=a, go to DONE (latency 1).
  - Shift with shamt>0: working reg=a, counter=shamt, go to SHIFT.
- SHIFT: each cycle, shift the working reg by 1 in the captured direction and decrement the counter. When the counter reaches 0, go to DONE with result = working reg.
  - Total latency from accept to out_valid = shamt+1 cycles.
  - Maximum latency = 2^SHAMT_W cycles (32 at defaults).
- DONE: result, zero and illegal are held stable while out_valid=1 && out_ready=0.
  - On out_valid && out_ready: go to IDLE next cycle.
  - No new request is accepted in the same cycle as the handoff, so the block sustains at most 1 operation per 2 cycles.
- zero and illegal are registered together with result and change only on entering DONE. They are meaningful only while out_valid=1.
- out_ready asserted outside DONE has no effect. in_valid asserted while in SHIFT or DONE is not consumed; the requester must hold it until in_ready.
- Reset, asynchronous, any state including mid-shift:
  - State=IDLE, in_ready=1, out_valid=0.
  - result=0, zero=0, illegal=0, counter=0.
  - Any in-flight op is discarded; no output is produced for it.
  - The first request is accepted on the first clock edge after reset deasserts.
- Outputs are registered (no combinational path from inputs to outputs), except in_ready, which is a decode of state.

Test Plan:
- Add wrap, sub to zero, sub below zero:
  - 0010, a=0xFFFFFFFF, b=0x00000002 -> result=0x00000001, zero=0, out_valid 1 cycle after accept.
  - 0110, a=b=0x1234 -> result=0, zero=1.
  - 0110, a=0x0, b=0x1 -> result=0xFFFFFFFF, zero=0, illegal=0.
- Logic ops, a=0xF0F0F0F0, b=0x0FF00FF0:
  - 0000 (and) -> 0x00F000F0.
  - 0001 (or) -> 0xFFF0FFF0.
  - 1100 (xor) -> 0xFF00FF00.
  - Each completes in 1 cycle.
- Shifts:
  - 0011, a=0x1, b=31 -> result=0x80000000, out_valid exactly 32 cycles after accept, in_ready=0 throughout.
  - 0100, a=0x80000000, b=0x24 (shamt=4) -> 0x08000000, 5-cycle latency.
  - Shamt=0 -> result=a, 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after an add completes -> result/zero/illegal stable, in_ready=0 and a new in_valid is not consumed. Raise out_ready -> in_ready=1 the next cycle, then the pending request is accepted.
- Illegal code: aluctl=0111 -> result=0, zero=1, illegal=1, 1-cycle latency. The next legal op clears illegal to 0.
- Reset mid-shift: assert reset asynchronously (between clock edges) 3 cycles into a 31-bit sll -> out_valid=0, in_ready=1, result=0 immediately. After release, an add 5+7 -> result=12, with no stale shift result ever presented.
